led_glow_engine: RTL

Parametrised multi-channel LED glow engine for the ULX3S samples; successor to the single-channel 4-bit glow/police-light design.
- Shared free-running PWM frame counter.
- Triangle "breathing" level ramp with programmable step rate.
- Per-channel group mask for alternating two-group patterns.
- Four runtime modes.
Sits between board top (clk_25mhz domain) and the led pins.

---
 rtl/led_glow_pkg.sv | 25 ++
 rtl/led_glow_engine_pwm_frame.sv | 58 +++++
 rtl/led_glow_engine.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/led_glow_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_glow_pkg
//  Description : Shared mode and ramp-direction definitions for the LED glow
//                engine and its PWM frame sub-block.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package led_glow_pkg;

    // Runtime operating mode as presented on the mode input
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'd0;
    localparam mode_t MODE_BREATHE = 2'd1;
    localparam mode_t MODE_ALT     = 2'd2;
    localparam mode_t MODE_STATIC  = 2'd3;

    // Direction of the triangle breathing ramp
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/led_glow_engine_pwm_frame.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_frame
//  Description : Shared free-running PWM frame counter with per-channel duty
//                registers that only update at the frame boundary, plus the
//                per-channel lit comparators.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module led_pwm_frame #(
    parameter int N_CH     = 8,
    parameter int PWM_BITS = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic [N_CH-1:0][PWM_BITS-1:0]      duty_next,
    output logic                               frame_end,
    output logic [N_CH-1:0]                    lit
);

    localparam logic [PWM_BITS-1:0] c_MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0]            r_pwm_cnt;
    logic [N_CH-1:0][PWM_BITS-1:0]  r_duty_cur;

    assign frame_end = (r_pwm_cnt == c_MAX);

    // Frame counter: free-running, wraps MAX->0, restarted by a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else if (clr) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Duty registers: load only on the last clock of a frame so a duty change never glitches mid-frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_cur <= '0;
        end else if (clr) begin
            r_duty_cur <= '0;
        end else if (frame_end) begin
            r_duty_cur <= duty_next;
        end
    end

    // Duty d lights a channel for counts 0..d-1, i.e. d clocks per frame
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign lit[gi] = (r_pwm_cnt < r_duty_cur[gi]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/led_glow_engine.sv
`default_nettype none
// ============================================================================
//  Module      : led_glow_engine
//  Description : Multi-channel LED glow engine: triangle breathing ramp with
//                programmable step rate, two-group alternate pattern, static
//                duty and off modes, driving registered LED outputs.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module led_glow_engine
    import led_glow_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int PWM_BITS    = 8,
    parameter int RAMP_DIV    = 97656,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  mode_t                mode,
    input  logic [N_CH-1:0]      group_mask,
    input  logic [PWM_BITS-1:0]  static_level,
    output logic [N_CH-1:0]      led,
    output logic [PWM_BITS-1:0]  level,
    output logic                 phase,
    output logic                 cycle_done
);

    localparam logic [PWM_BITS-1:0] c_MAX        = {PWM_BITS{1'b1}};
    localparam int                  c_PRESC_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(RAMP_DIV - 1);
    // XOR mask turning "lit" into the pin level; all ones inverts for active-low LEDs
    localparam logic [N_CH-1:0]     c_LED_OFF    = {N_CH{(ACTIVE_HIGH == 0)}};

    mode_t                          r_mode_q;
    logic [c_PRESC_W-1:0]           r_presc;
    logic [PWM_BITS-1:0]            r_level;
    dir_t                           r_dir;
    logic                           r_phase;
    logic                           r_cycle_done;
    logic [N_CH-1:0]                r_led;

    logic                           w_clr;
    logic                           w_ramp_en;
    logic                           w_tick;
    logic [PWM_BITS-1:0]            w_level_inc;
    logic [PWM_BITS-1:0]            w_level_dec;
    logic [N_CH-1:0][PWM_BITS-1:0]  w_duty_next;
    logic [N_CH-1:0]                w_lit;
    // Frame boundary strobe of the PWM block; the ramp runs on its own prescaler
    logic                           w_unused_frame_end;

    // Any mode change restarts everything from a clean state
    assign w_clr       = !enable || (mode != r_mode_q);
    assign w_ramp_en   = (r_mode_q == MODE_BREATHE) || (r_mode_q == MODE_ALT);
    assign w_tick      = w_ramp_en && (r_presc == c_PRESC_LAST);
    assign w_level_inc = r_level + 1'b1;
    assign w_level_dec = r_level - 1'b1;

    // Track the mode the engine was last cleared into
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= MODE_OFF;
        end else if (w_clr) begin
            r_mode_q <= mode;
        end
    end

    // Prescaler and triangle ramp; held at zero/up outside the ramping modes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_level      <= '0;
            r_dir        <= DIR_UP;
            r_phase      <= 1'b0;
            r_cycle_done <= 1'b0;
        end else if (w_clr || !w_ramp_en) begin
            r_presc      <= '0;
            r_level      <= '0;
            r_dir        <= DIR_UP;
            r_phase      <= 1'b0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            if (w_tick) begin
                r_presc <= '0;
                if (r_dir == DIR_UP) begin
                    r_level <= w_level_inc;
                    if (w_level_inc == c_MAX) begin
                        r_dir <= DIR_DOWN;
                    end
                end else begin
                    r_level <= w_level_dec;
                    if (w_level_dec == '0) begin
                        r_dir        <= DIR_UP;
                        r_phase      <= ~r_phase;
                        r_cycle_done <= 1'b1;
                    end
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Per-channel target duty for the next frame, chosen by the active mode
    always_comb begin
        w_duty_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (r_mode_q)
                MODE_BREATHE: w_duty_next[i] = r_level;
                MODE_ALT: begin
                    if (group_mask[i] == r_phase) begin
                        w_duty_next[i] = r_level;
                    end
                end
                MODE_STATIC:  w_duty_next[i] = static_level;
                default:      w_duty_next[i] = '0;
            endcase
        end
    end

    led_pwm_frame #(
        .N_CH     (N_CH),
        .PWM_BITS (PWM_BITS)
    ) u_pwm_frame (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_clr),
        .duty_next (w_duty_next),
        .frame_end (w_unused_frame_end),
        .lit       (w_lit)
    );

    // Registered pin drive; a clear darkens the LEDs on the very next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= c_LED_OFF;
        end else if (w_clr) begin
            r_led <= c_LED_OFF;
        end else begin
            r_led <= w_lit ^ c_LED_OFF;
        end
    end

    assign led        = r_led;
    assign level      = r_level;
    assign phase      = r_phase;
    assign cycle_done = r_cycle_done;

endmodule
`default_nettype wire
